// File: rtl/tap_misr_compactor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tap_misr_pkg                                                     |
// | Shared definitions for the tap MISR compactor: FSM state encoding, default |
// | polynomial and seed, and the single-step MISR update function.             |
// | No ports (package).                                                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package tap_misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] c_DEF_POLY = 16'h1021;
  localparam logic [15:0] c_DEF_SEED = 16'hFFFF;

  // Widest signature the step function handles; callers zero-extend into it.
  localparam int unsigned c_MAX_W = 32;

  // One Galois MISR step on a 'width'-bit signature held in the low bits of
  // a c_MAX_W container. The x^width term is implicit: the bit shifted out
  // of the top selects whether poly is folded back in.
  function automatic logic [c_MAX_W-1:0] misr_next(
    input logic [c_MAX_W-1:0] sig,
    input logic [c_MAX_W-1:0] poly,
    input logic [c_MAX_W-1:0] tap,
    input int unsigned        width
  );
    logic [c_MAX_W:0]   one;
    logic [c_MAX_W:0]   mask_ext;
    logic [c_MAX_W-1:0] mask;
    logic               msb;
    one      = {{c_MAX_W{1'b0}}, 1'b1};
    mask_ext = (one << width) - one;
    mask     = mask_ext[c_MAX_W-1:0];
    // mask ^ (mask >> 1) isolates the top signature bit without a variable index
    msb      = |(sig & (mask ^ (mask >> 1)));
    return ((sig << 1) ^ (msb ? poly : '0) ^ tap) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tap_misr_compactor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : tap_misr_compactor_if                                          |
// | Control, tap and status bundle between a driver and the MISR compactor.    |
// |   cen       : shared clock enable      tap       : scrambler taps          |
// |   start     : begin a run              len       : samples to take         |
// |   busy      : run in progress          done      : signature final         |
// |   signature : running/final MISR       remaining : samples still to take   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface tap_misr_compactor_if #(
  parameter int unsigned SIG_W = 16,
  parameter int unsigned TAP_W = 4,
  parameter int unsigned LEN_W = 8
);
  logic             cen;
  logic [TAP_W-1:0] tap;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [LEN_W-1:0] remaining;

  modport master (
    output cen, tap, start, len,
    input  busy, done, signature, remaining
  );

  modport slave (
    input  cen, tap, start, len,
    output busy, done, signature, remaining
  );
endinterface
`default_nettype wire

// File: rtl/tap_misr_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tap_misr_compactor                                                |
// | Compacts the scrambler's tap outputs into a Galois MISR over a programmed  |
// | number of cen-qualified cycles, then holds the signature for comparison.   |
// |   clk   : rising-edge clock       rst_n : asynchronous reset, active-low   |
// |   bus   : tap_misr_compactor_if slave (cen/tap/start/len in,               |
// |           busy/done/signature/remaining out)                               |
// | SIG_W must satisfy TAP_W <= SIG_W <= 32.                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tap_misr_compactor
  import tap_misr_pkg::*;
#(
  parameter int unsigned     SIG_W = 16,
  parameter int unsigned     TAP_W = 4,
  parameter int unsigned     LEN_W = 8,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(c_DEF_POLY),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(c_DEF_SEED)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  tap_misr_compactor_if.slave    bus
);

  state_e             r_state;
  state_e             w_state_next;
  logic [SIG_W-1:0]   r_sig;
  logic [LEN_W-1:0]   r_rem;

  logic               w_start_ok;
  logic               w_sample;
  logic               w_last;
  logic               w_busy;
  logic               w_done;
  logic [c_MAX_W-1:0] w_step_ext;
  logic [SIG_W-1:0]   w_step;
  logic               w_unused;

  // start is not cen-qualified, but a running compaction cannot be restarted
  assign w_start_ok = bus.start && (r_state != ST_RUN);
  assign w_sample   = (r_state == ST_RUN) && bus.cen;
  // In RUN remaining is always >= 1, so the final sample is the one taken at 1
  assign w_last     = w_sample && (r_rem == LEN_W'(1));

  assign w_step_ext = misr_next(c_MAX_W'(r_sig), c_MAX_W'(POLY), c_MAX_W'(bus.tap), SIG_W);
  assign w_step     = w_step_ext[SIG_W-1:0];
  // Upper container bits are always zero after masking
  assign w_unused   = ^w_step_ext;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_state_next = (bus.len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_RUN:  w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Signature and sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
      r_rem <= '0;
    end else if (w_start_ok) begin
      r_sig <= SEED;
      r_rem <= bus.len;
    end else if (w_sample) begin
      r_sig <= w_step;
      if (r_rem != '0) begin
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.signature = r_sig;
  assign bus.remaining = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_tap_misr_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_tap_misr_compactor                                             |
// | Self-checking bench: two compactors (SEED=0000 and SEED=FFFF) driven with  |
// | identical stimulus; expected signatures and latencies are queued at issue  |
// | and compared by a monitor on each rising done.                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tap_misr_compactor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tap_misr_compactor_if #(.SIG_W(16), .TAP_W(4), .LEN_W(8)) if_a ();
  tap_misr_compactor_if #(.SIG_W(16), .TAP_W(4), .LEN_W(8)) if_b ();

  tap_misr_compactor #(
    .SIG_W(16), .TAP_W(4), .LEN_W(8), .POLY(16'h1021), .SEED(16'h0000)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_a)
  );

  tap_misr_compactor #(
    .SIG_W(16), .TAP_W(4), .LEN_W(8), .POLY(16'h1021), .SEED(16'hFFFF)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_b)
  );

  typedef struct {
    logic [15:0] sig_a;
    logic [15:0] sig_b;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent reference step: x^16 + x^12 + x^5 + 1 Galois MISR
  function automatic logic [15:0] m_step(input logic [15:0] s, input logic [3:0] t);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, t};
  endfunction

  // Cycle-level model of the run, updated by the stimulus thread
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  int          m_rem    = 0;
  int          m_lat    = 0;
  int          m_start  = 0;
  logic [15:0] m_sa     = 16'h0;
  logic [15:0] m_sb     = 16'h0;

  // Drive one cycle, advance the model, then check status after the edge
  task automatic cyc1(input logic s, input logic [7:0] l, input logic c, input logic [3:0] t);
    if_a.start = s; if_a.len = l; if_a.cen = c; if_a.tap = t;
    if_b.start = s; if_b.len = l; if_b.cen = c; if_b.tap = t;
    if (m_active) begin
      m_lat++;
      if (c) begin
        m_sa = m_step(m_sa, t);
        m_sb = m_step(m_sb, t);
        m_rem--;
        if (m_rem == 0) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          q.push_back('{m_sa, m_sb, m_lat, m_start});
        end
      end
    end else if (s) begin
      m_sa    = 16'h0000;
      m_sb    = 16'hFFFF;
      m_rem   = int'(l);
      m_lat   = 1;
      m_start = cyc + 1;
      if (l == 8'd0) begin
        m_done = 1'b1;
        q.push_back('{m_sa, m_sb, m_lat, m_start});
      end else begin
        m_active = 1'b1;
        m_done   = 1'b0;
      end
    end
    @(negedge clk);
    check("busy_a", {31'b0, if_a.busy}, {31'b0, m_active});
    check("busy_b", {31'b0, if_b.busy}, {31'b0, m_active});
    check("done_a", {31'b0, if_a.done}, {31'b0, m_done});
    check("remaining_a", {24'b0, if_a.remaining}, m_rem);
    check("remaining_b", {24'b0, if_b.remaining}, m_rem);
  endtask

  // Scoreboard monitor: one queued expectation per rising done
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (if_a.done && !prev_done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("sb_sig_a", {16'b0, if_a.signature}, {16'b0, q[0].sig_a});
        check("sb_sig_b", {16'b0, if_b.signature}, {16'b0, q[0].sig_b});
        check("sb_done_b", {31'b0, if_b.done}, 32'd1);
        check("sb_latency", cyc - q[0].start_cyc + 1, q[0].lat);
        void'(q.pop_front());
      end
    end
    prev_done <= if_a.done;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [31:0] scr;
  logic [3:0]  stap;
  logic        scen;

  initial begin
    if_a.start = 1'b0; if_a.len = 8'd0; if_a.cen = 1'b0; if_a.tap = 4'h0;
    if_b.start = 1'b0; if_b.len = 8'd0; if_b.cen = 1'b0; if_b.tap = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'b0, if_a.busy}, 32'd0);
    check("rst_done",  {31'b0, if_a.done}, 32'd0);
    check("rst_sig_a", {16'b0, if_a.signature}, 32'd0);
    check("rst_sig_b", {16'b0, if_b.signature}, 32'd0);
    check("rst_rem",   {24'b0, if_a.remaining}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // len=0 from IDLE: straight to DONE, signature = SEED, busy stays 0
    cyc1(1'b1, 8'd0, 1'b1, 4'h0);
    check("len0_sig_a", {16'b0, if_a.signature}, 32'h0000);
    check("len0_sig_b", {16'b0, if_b.signature}, 32'hFFFF);
    cyc1(1'b0, 8'd0, 1'b1, 4'h0);

    // len=1, tap=A
    cyc1(1'b1, 8'd1, 1'b1, 4'h0);
    cyc1(1'b0, 8'd0, 1'b1, 4'hA);
    check("t1_sig_a", {16'b0, if_a.signature}, 32'h000A);
    check("t1_sig_b", {16'b0, if_b.signature}, 32'hEFD5);

    // len=1, tap=0: pure shift with polynomial feedback from FFFF
    cyc1(1'b1, 8'd1, 1'b1, 4'h0);
    cyc1(1'b0, 8'd0, 1'b1, 4'h0);
    check("t2_sig_b", {16'b0, if_b.signature}, 32'hEFDF);

    // len=2, tap=1, cen 1,0,1
    cyc1(1'b1, 8'd2, 1'b1, 4'h0);
    cyc1(1'b0, 8'd0, 1'b1, 4'h1);
    check("t3_sig_a_1", {16'b0, if_a.signature}, 32'h0001);
    cyc1(1'b0, 8'd0, 1'b0, 4'h1);
    check("t3_sig_a_hold", {16'b0, if_a.signature}, 32'h0001);
    cyc1(1'b0, 8'd0, 1'b1, 4'h1);
    check("t3_sig_a_2", {16'b0, if_a.signature}, 32'h0003);

    // len=8 with a start pulse mid-run that must be ignored
    cyc1(1'b1, 8'd8, 1'b1, 4'h0);
    for (int i = 0; i < 8; i++) begin
      cyc1((i == 3), 8'd5, 1'b1, 4'(i * 5 + 3));
    end
    // restart from DONE with cen low: start is still accepted
    cyc1(1'b1, 8'd3, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc1(1'b0, 8'd0, 1'b1, 4'(15 - i));
    end

    // async reset mid-run, checked between clock edges
    cyc1(1'b1, 8'd200, 1'b1, 4'h0);
    for (int i = 0; i < 4; i++) cyc1(1'b0, 8'd0, 1'b1, 4'h7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy_a", {31'b0, if_a.busy}, 32'd0);
    check("arst_done_a", {31'b0, if_a.done}, 32'd0);
    check("arst_sig_a",  {16'b0, if_a.signature}, 32'd0);
    check("arst_sig_b",  {16'b0, if_b.signature}, 32'd0);
    check("arst_rem_b",  {24'b0, if_b.remaining}, 32'd0);
    m_active = 1'b0; m_done = 1'b0; m_rem = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // full-length run fed by a 32-bit shift/XOR scrambler stand-in
    scr = 32'h1234_5678;
    cyc1(1'b1, 8'd255, 1'b1, 4'h0);
    for (int i = 0; i < 600 && m_active; i++) begin
      stap = {scr[15], scr[9], scr[5], scr[3]};
      scen = ((i % 4) != 3);
      cyc1(1'b0, 8'd0, scen, stap);
      if (scen) scr = {scr[30:0], scr[31] ^ scr[21] ^ scr[1] ^ scr[0]};
    end
    check("full_run_finished", {31'b0, m_active}, 32'd0);
    repeat (3) cyc1(1'b0, 8'd0, 1'b1, 4'h0);
    check("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
